// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the fetch port, the load/store port and the
// RAM macro port that meet at mem_port_arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/responses/RAM).
//   master : the surrounding view (IF/MEM stages plus the RAM macro).
// Ports: if_* fetch handshake, d_* load/store handshake, ram_* RAM macro pins.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);

  // Instruction-fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // MEM-stage load/store port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [2:0]        d_rw_op;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_misalign;

  // RAM macro port
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_rw_op,
    output d_gnt, d_rvalid, d_rdata, d_misalign,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_rw_op,
    input  d_gnt, d_rvalid, d_rdata, d_misalign,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port and the MEM-stage load/store port. One grant per
// cycle (data preferred, fetch protected by a starvation counter), byte-lane
// steering for stores, and one-cycle-later read responses with load
// extraction and sign/zero extension chosen by funct3.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   bus_io  : mem_port_arbiter_if.slave (fetch, load/store and RAM ports)
// Grants and ram_* are combinational from the requests and registered state;
// rvalid/rdata are decoded from the registered response-owner state.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus_io
);

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]          rsp_op_q, rsp_op_d;
  logic [1:0]          rsp_off_q, rsp_off_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic                d_fault_c;
  logic                if_starved_c;
  logic                if_gnt_c;
  logic                d_gnt_c;
  logic                ram_en_c;
  logic [3:0]          ram_we_c;
  logic [ADDR_W-1:0]   ram_addr_c;
  logic [DATA_W-1:0]   ram_wdata_c;
  logic                if_rvalid_c;
  logic                d_rvalid_c;
  logic [DATA_W-1:0]   rsp_shift_c;
  logic [DATA_W-1:0]   load_ext_c;
  logic [DATA_W-1:0]   d_rdata_c;

  // Address bits that never reach the RAM word address.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{bus_io.if_addr[DATA_W-1:ADDR_W+2],
                              bus_io.if_addr[1:0],
                              bus_io.d_addr[DATA_W-1:ADDR_W+2]};

  // Misaligned halfword/word accesses and unused funct3 codes are faults.
  always_comb begin
    d_fault_c = 1'b1;
    unique case (bus_io.d_rw_op)
      3'b000, 3'b100: d_fault_c = 1'b0;
      3'b001, 3'b101: d_fault_c = bus_io.d_addr[0];
      3'b010:         d_fault_c = |bus_io.d_addr[1:0];
      default:        d_fault_c = 1'b1;
    endcase
  end

  // Data wins a collision unless fetch has already waited MAX_WAIT cycles.
  assign if_starved_c = (wait_cnt_q == WAIT_W'(MAX_WAIT));
  assign d_gnt_c      = rst_n & bus_io.d_req & ~(bus_io.if_req & if_starved_c);
  assign if_gnt_c     = rst_n & bus_io.if_req & ~d_gnt_c;

  // RAM drive for the granted port; a faulting data access never touches RAM.
  always_comb begin
    ram_en_c    = 1'b0;
    ram_we_c    = 4'b0000;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    if (if_gnt_c) begin
      ram_en_c   = 1'b1;
      ram_addr_c = bus_io.if_addr[ADDR_W+1:2];
    end else if (d_gnt_c && !d_fault_c) begin
      ram_en_c   = 1'b1;
      ram_addr_c = bus_io.d_addr[ADDR_W+1:2];
      if (bus_io.d_we) begin
        // Size is funct3[1:0]; replicated data lets the RAM pick any lane.
        unique case (bus_io.d_rw_op[1:0])
          2'b00: begin
            ram_we_c    = 4'b0001 << bus_io.d_addr[1:0];
            ram_wdata_c = {4{bus_io.d_wdata[7:0]}};
          end
          2'b01: begin
            ram_we_c    = 4'b0011 << bus_io.d_addr[1:0];
            ram_wdata_c = {2{bus_io.d_wdata[15:0]}};
          end
          2'b10: begin
            ram_we_c    = 4'b1111;
            ram_wdata_c = bus_io.d_wdata;
          end
          default: begin
            ram_we_c    = 4'b0000;
            ram_wdata_c = '0;
          end
        endcase
      end
    end
  end

  // Next-state: response owner, starvation counter and load-response context.
  always_comb begin
    state_d    = IDLE;
    wait_cnt_d = '0;
    rsp_op_d   = rsp_op_q;
    rsp_off_d  = rsp_off_q;
    rsp_zero_d = rsp_zero_q;

    if (bus_io.if_req && !if_gnt_c) begin
      wait_cnt_d = if_starved_c ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end

    if (if_gnt_c) begin
      state_d = RESP_IF;
    end else if (d_gnt_c && !bus_io.d_we) begin
      state_d    = RESP_D;
      rsp_op_d   = bus_io.d_rw_op;
      rsp_off_d  = bus_io.d_addr[1:0];
      rsp_zero_d = d_fault_c;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rsp_op_q   <= '0;
      rsp_off_q  <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_op_q   <= rsp_op_d;
      rsp_off_q  <= rsp_off_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  // Holding reset low suppresses a response still owed from the prior cycle.
  assign if_rvalid_c = rst_n & (state_q == RESP_IF);
  assign d_rvalid_c  = rst_n & (state_q == RESP_D);

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign rsp_shift_c = bus_io.ram_rdata >> {rsp_off_q, 3'b000};

  always_comb begin
    load_ext_c = '0;
    unique case (rsp_op_q)
      3'b000:  load_ext_c = {{24{rsp_shift_c[7]}},  rsp_shift_c[7:0]};
      3'b001:  load_ext_c = {{16{rsp_shift_c[15]}}, rsp_shift_c[15:0]};
      3'b010:  load_ext_c = rsp_shift_c;
      3'b100:  load_ext_c = {24'd0, rsp_shift_c[7:0]};
      3'b101:  load_ext_c = {16'd0, rsp_shift_c[15:0]};
      default: load_ext_c = '0;
    endcase
  end

  assign d_rdata_c = (d_rvalid_c && !rsp_zero_q) ? load_ext_c : '0;

  assign bus_io.if_gnt     = if_gnt_c;
  assign bus_io.d_gnt      = d_gnt_c;
  assign bus_io.d_misalign = d_gnt_c & d_fault_c;
  assign bus_io.ram_en     = ram_en_c;
  assign bus_io.ram_we     = ram_we_c;
  assign bus_io.ram_addr   = ram_addr_c;
  assign bus_io.ram_wdata  = ram_wdata_c;
  assign bus_io.if_rvalid  = if_rvalid_c;
  assign bus_io.if_rdata   = if_rvalid_c ? bus_io.ram_rdata : '0;
  assign bus_io.d_rvalid   = d_rvalid_c;
  assign bus_io.d_rdata    = d_rdata_c;

endmodule
